hilo_pipe: RTL and testbench

- Consumer side of the EX stage's HI/LO write interface (`ex_whilo`, `ex_hi`, `ex_lo`).
- Carries HI/LO writes through MEM and WB pipeline registers, commits them to the architectural HI/LO pair, and returns forwarded HI/LO values to EX's `hi_i`/`lo_i` inputs.
- Sits between EX and the writeback logic, beside the GPR file.
- Handles stall bubbles and flush.

---
 rtl/hilo_pipe_pkg.sv | 19 +
 rtl/hilo_stage.sv | 64 ++++++
 rtl/hilo_pipe.sv | 105 ++++++++++
 tb/tb_hilo_pipe.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pipe_pkg.sv
// Shared constants for the HI/LO pipeline: reset polarity, write-enable
// encodings, bus widths and a small helper for counting in-flight writes.
package hilo_pipe_pkg;

    localparam logic RstEnable    = 1'b0;  // rst is active low
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 2 * RegBus;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    // Number of set valid bits among two stage registers (0..2).
    function automatic logic [1:0] count_valid(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/hilo_stage.sv
// One HI/LO pipeline register {whilo, hi, lo}. A flush clears it. When the
// upstream stage stalls but this stage does not, a bubble is loaded so the
// same upstream entry is not duplicated downstream. When neither stalls it
// captures the upstream entry, and when both stall it holds.
module hilo_stage
    import hilo_pipe_pkg::*;
#(
    parameter int DW = RegBus
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          stall_in,   // stage feeding this register is stalled
    input  logic          stall_out,  // this stage is stalled
    input  logic          whilo_in,
    input  logic [DW-1:0] hi_in,
    input  logic [DW-1:0] lo_in,
    output logic          whilo_o,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o
);

    logic          whilo_q, whilo_d;
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;

    // Next-state selection: flush, then bubble, then capture, else hold.
    always_comb begin
        whilo_d = whilo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (flush) begin
            whilo_d = WriteDisable;
            hi_d    = '0;
            lo_d    = '0;
        end else if (stall_in && !stall_out) begin
            whilo_d = WriteDisable;
            hi_d    = '0;
            lo_d    = '0;
        end else if (!stall_in) begin
            whilo_d = whilo_in;
            hi_d    = hi_in;
            lo_d    = lo_in;
        end
    end

    // Stage register with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            whilo_q <= WriteDisable;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            whilo_q <= whilo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign whilo_o = whilo_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: rtl/hilo_pipe.sv
// HI/LO write path from EX through MEM and WB to the architectural HI/LO
// pair. Provides forwarding back to EX (youngest in-flight write wins), a
// one-cycle commit pulse and a count of in-flight writes.
module hilo_pipe
    import hilo_pipe_pkg::*;
#(
    parameter int DW = RegBus
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_whilo,
    input  logic [DW-1:0] ex_hi,
    input  logic [DW-1:0] ex_lo,
    input  logic          stall_ex,
    input  logic          stall_mem,
    input  logic          stall_wb,
    input  logic          flush,
    output logic [DW-1:0] hi_fwd,
    output logic [DW-1:0] lo_fwd,
    output logic [DW-1:0] hi_arch,
    output logic [DW-1:0] lo_arch,
    output logic          commit,
    output logic [1:0]    pending
);

    logic          mem_whilo, wb_whilo;
    logic [DW-1:0] mem_hi, mem_lo, wb_hi, wb_lo;

    logic [DW-1:0] hi_arch_q, hi_arch_d;
    logic [DW-1:0] lo_arch_q, lo_arch_d;
    logic          commit_q, commit_d;

    hilo_stage #(.DW(DW)) u_mem (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .stall_in  (stall_ex),
        .stall_out (stall_mem),
        .whilo_in  (ex_whilo),
        .hi_in     (ex_hi),
        .lo_in     (ex_lo),
        .whilo_o   (mem_whilo),
        .hi_o      (mem_hi),
        .lo_o      (mem_lo)
    );

    hilo_stage #(.DW(DW)) u_wb (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .stall_in  (stall_mem),
        .stall_out (stall_wb),
        .whilo_in  (mem_whilo),
        .hi_in     (mem_hi),
        .lo_in     (mem_lo),
        .whilo_o   (wb_whilo),
        .hi_o      (wb_hi),
        .lo_o      (wb_lo)
    );

    // Commit decision: the WB entry retires whenever WB is not stalled.
    // A flush on the same edge still lets the entry already in WB retire.
    always_comb begin
        hi_arch_d = hi_arch_q;
        lo_arch_d = lo_arch_q;
        commit_d  = 1'b0;
        if (wb_whilo == WriteEnable && !stall_wb) begin
            hi_arch_d = wb_hi;
            lo_arch_d = wb_lo;
            commit_d  = 1'b1;
        end
    end

    // Architectural HI/LO and the registered commit pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            hi_arch_q <= '0;
            lo_arch_q <= '0;
            commit_q  <= 1'b0;
        end else begin
            hi_arch_q <= hi_arch_d;
            lo_arch_q <= lo_arch_d;
            commit_q  <= commit_d;
        end
    end

    // Forward mux: MEM is younger than WB, which is younger than committed.
    always_comb begin
        hi_fwd = hi_arch_q;
        lo_fwd = lo_arch_q;
        if (mem_whilo == WriteEnable) begin
            hi_fwd = mem_hi;
            lo_fwd = mem_lo;
        end else if (wb_whilo == WriteEnable) begin
            hi_fwd = wb_hi;
            lo_fwd = wb_lo;
        end
    end

    assign hi_arch = hi_arch_q;
    assign lo_arch = lo_arch_q;
    assign commit  = commit_q;
    assign pending = count_valid(mem_whilo, wb_whilo);

endmodule

// File: tb/tb_hilo_pipe.sv
// Directed bench for hilo_pipe. Expected commits are queued when a write is
// driven and popped whenever the DUT raises its commit pulse.
module tb_hilo_pipe;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          ex_whilo;
    logic [DW-1:0] ex_hi, ex_lo;
    logic          stall_ex, stall_mem, stall_wb, flush;
    logic [DW-1:0] hi_fwd, lo_fwd, hi_arch, lo_arch;
    logic          commit;
    logic [1:0]    pending;

    int passed = 0;
    int total  = 0;

    logic [2*DW-1:0] exp_q[$];

    hilo_pipe #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_whilo  (ex_whilo),
        .ex_hi     (ex_hi),
        .ex_lo     (ex_lo),
        .stall_ex  (stall_ex),
        .stall_mem (stall_mem),
        .stall_wb  (stall_wb),
        .flush     (flush),
        .hi_fwd    (hi_fwd),
        .lo_fwd    (lo_fwd),
        .hi_arch   (hi_arch),
        .lo_arch   (lo_arch),
        .commit    (commit),
        .pending   (pending)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one edge, sample 1 time unit later, and retire the scoreboard
    // head whenever a commit pulse is seen.
    task automatic tick();
        logic [2*DW-1:0] exp_v;
        @(posedge clk);
        #1;
        if (commit === 1'b1) begin
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : {2*DW{1'b1}};
            chk("sb_commit", {hi_arch, lo_arch}, exp_v);
        end
    endtask

    task automatic drive_write(input logic [DW-1:0] h, input logic [DW-1:0] l, input bit expect_commit);
        ex_whilo = 1'b1;
        ex_hi    = h;
        ex_lo    = l;
        if (expect_commit) exp_q.push_back({h, l});
    endtask

    task automatic idle();
        ex_whilo = 1'b0;
        ex_hi    = '0;
        ex_lo    = '0;
    endtask

    initial begin
        logic [DW-1:0] hold_hi;

        // 1. Reset held while EX drives a write
        rst = 1'b0; flush = 1'b0;
        stall_ex = 1'b0; stall_mem = 1'b0; stall_wb = 1'b0;
        ex_whilo = 1'b1; ex_hi = 32'hFFFF_FFFF; ex_lo = 32'hFFFF_FFFF;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("rst_hi_fwd", hi_fwd, 0);
        chk("rst_lo_fwd", lo_fwd, 0);
        chk("rst_hi_arch", hi_arch, 0);
        chk("rst_lo_arch", lo_arch, 0);
        chk("rst_commit", commit, 0);
        chk("rst_pending", pending, 0);
        idle();
        rst = 1'b1;
        tick();
        chk("post_rst_commit", commit, 0);
        chk("post_rst_pending", pending, 0);

        // 2. Single write
        drive_write(32'h1234_5678, 32'h9ABC_DEF0, 1);
        tick();
        idle();
        chk("single_mem_hi_fwd", hi_fwd, 32'h1234_5678);
        chk("single_mem_lo_fwd", lo_fwd, 32'h9ABC_DEF0);
        chk("single_mem_pending", pending, 1);
        chk("single_mem_commit", commit, 0);
        tick();
        chk("single_wb_pending", pending, 1);
        chk("single_wb_hi_fwd", hi_fwd, 32'h1234_5678);
        chk("single_wb_hi_arch", hi_arch, 0);
        chk("single_wb_commit", commit, 0);
        tick();
        chk("single_hi_arch", hi_arch, 32'h1234_5678);
        chk("single_lo_arch", lo_arch, 32'h9ABC_DEF0);
        chk("single_commit", commit, 1);
        chk("single_pending0", pending, 0);
        tick();
        chk("single_commit_end", commit, 0);

        // 3. Back-to-back writes
        drive_write(32'd1, 32'd2, 1);
        tick();
        drive_write(32'd3, 32'd4, 1);
        tick();
        idle();
        chk("b2b_hi_fwd", hi_fwd, 3);
        chk("b2b_lo_fwd", lo_fwd, 4);
        chk("b2b_pending", pending, 2);
        tick();
        chk("b2b_commit_a", commit, 1);
        chk("b2b_hi_arch_a", hi_arch, 1);
        chk("b2b_pending_a", pending, 1);
        chk("b2b_hi_fwd_wb", hi_fwd, 3);
        tick();
        chk("b2b_commit_b", commit, 1);
        chk("b2b_hi_arch_b", hi_arch, 3);
        chk("b2b_lo_arch_b", lo_arch, 4);
        chk("b2b_pending_b", pending, 0);
        tick();
        chk("b2b_commit_end", commit, 0);

        // 4. Stall bubble behind a write
        drive_write(32'h0000_A5A5, 32'h0000_5A5A, 1);
        tick();
        stall_ex = 1'b1;
        drive_write(32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
        tick();
        chk("bub_pending", pending, 1);
        chk("bub_hi_fwd", hi_fwd, 32'h0000_A5A5);
        tick();
        chk("bub_commit", commit, 1);
        chk("bub_hi_arch", hi_arch, 32'h0000_A5A5);
        chk("bub_pending0", pending, 0);
        stall_ex = 1'b0;
        idle();
        tick();
        chk("bub_commit_end", commit, 0);
        chk("bub_pending_end", pending, 0);

        // 5. Full stall with an entry in WB
        drive_write(32'h0000_0011, 32'h0000_0022, 1);
        tick();
        idle();
        tick();
        chk("fs_pending_wb", pending, 1);
        hold_hi = 32'h0000_0011;
        stall_ex = 1'b1; stall_mem = 1'b1; stall_wb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fs_no_commit", commit, 0);
            chk("fs_hi_fwd", hi_fwd, hold_hi);
            chk("fs_hi_arch", hi_arch, 32'h0000_A5A5);
            chk("fs_pending", pending, 1);
        end
        stall_ex = 1'b0; stall_mem = 1'b0; stall_wb = 1'b0;
        tick();
        chk("fs_release_commit", commit, 1);
        chk("fs_release_hi_arch", hi_arch, 32'h0000_0011);
        chk("fs_release_lo_arch", lo_arch, 32'h0000_0022);
        tick();

        // 6. Flush (with stalls also high) while MEM and WB hold entries
        drive_write(32'd5, 32'd55, 1);
        tick();
        drive_write(32'd7, 32'd77, 0);
        tick();
        idle();
        chk("fl_pending2", pending, 2);
        chk("fl_hi_fwd_mem", hi_fwd, 7);
        flush = 1'b1; stall_ex = 1'b1; stall_mem = 1'b1;
        tick();
        flush = 1'b0; stall_ex = 1'b0; stall_mem = 1'b0;
        chk("fl_commit", commit, 1);
        chk("fl_hi_arch", hi_arch, 5);
        chk("fl_pending", pending, 0);
        chk("fl_hi_fwd", hi_fwd, 5);
        chk("fl_lo_fwd", lo_fwd, 55);
        tick();
        chk("fl_no_second_commit", commit, 0);
        chk("fl_hi_arch_kept", hi_arch, 5);

        // 7. Asynchronous reset with a write in flight
        drive_write(32'd9, 32'd99, 0);
        tick();
        idle();
        tick();
        chk("ar_pending_before", pending, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_hi_arch", hi_arch, 0);
        chk("ar_lo_arch", lo_arch, 0);
        chk("ar_pending", pending, 0);
        chk("ar_hi_fwd", hi_fwd, 0);
        chk("ar_commit", commit, 0);
        #1;
        rst = 1'b1;
        tick();
        tick();
        chk("ar_no_commit", commit, 0);
        chk("ar_hi_arch_after", hi_arch, 0);

        chk("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
